uart_axil_bridge: RTL and testbench

- UART-command-driven AXI-lite initiator: the master side that drives memory-mapped peripherals, including the UART peripheral, from a host link.
- Consumes a received-byte stream from the shared uart core, parses fixed-length read/write command frames, issues one AXI-lite transaction per frame, and returns a status/data frame over the uart transmit path.
- Sits between the uart core (rx_done/rx_data, send_data/tx_done) and the AXI-lite interconnect as a debug/load port.

---
 rtl/uart_axil_bridge_if.sv | 52 +++++
 rtl/uart_axil_bridge.sv | 172 +++++++++++++++++
 tb/tb_uart_axil_bridge.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_axil_bridge_if.sv
// AXI-lite initiator bus seen from the UART command bridge.
// The master modport is the bridge side; the slave modport is the
// interconnect/peripheral side.
interface uart_axil_bridge_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  m_awvalid_o;
   logic [ADDR_WIDTH-1:0] m_awaddr_o;
   logic [2:0]            m_awprot_o;
   logic                  m_awready_i;
   logic                  m_wvalid_o;
   logic [31:0]           m_wdata_o;
   logic [3:0]            m_wstrb_o;
   logic                  m_wready_i;
   logic                  m_bvalid_i;
   logic [1:0]            m_bresp_i;
   logic                  m_bready_o;
   logic                  m_arvalid_o;
   logic [ADDR_WIDTH-1:0] m_araddr_o;
   logic [2:0]            m_arprot_o;
   logic                  m_arready_i;
   logic                  m_rvalid_i;
   logic [31:0]           m_rdata_i;
   logic [1:0]            m_rresp_i;
   logic                  m_rready_o;

   modport master (
      output m_awvalid_o, m_awaddr_o, m_awprot_o,
      input  m_awready_i,
      output m_wvalid_o, m_wdata_o, m_wstrb_o,
      input  m_wready_i,
      input  m_bvalid_i, m_bresp_i,
      output m_bready_o,
      output m_arvalid_o, m_araddr_o, m_arprot_o,
      input  m_arready_i,
      input  m_rvalid_i, m_rdata_i, m_rresp_i,
      output m_rready_o
   );

   modport slave (
      input  m_awvalid_o, m_awaddr_o, m_awprot_o,
      output m_awready_i,
      input  m_wvalid_o, m_wdata_o, m_wstrb_o,
      output m_wready_i,
      output m_bvalid_i, m_bresp_i,
      input  m_bready_o,
      input  m_arvalid_o, m_araddr_o, m_arprot_o,
      output m_arready_i,
      output m_rvalid_i, m_rdata_i, m_rresp_i,
      input  m_rready_o
   );
endinterface

// File: rtl/uart_axil_bridge.sv
// UART command frame -> AXI-lite initiator.
// Write frame: 'W' A3..A0 D3..D0, read frame: 'R' A3..A0 (MSB first).
// One AXI-lite transaction per frame, answered with 'K'/'E' (+4 data
// bytes on a successful read) over the uart transmit path.
module uart_axil_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid_i,
   input  logic [7:0] rx_byte_i,
   output logic       tx_start_o,
   output logic [7:0] tx_byte_o,
   input  logic       tx_done_i,
   uart_axil_bridge_if.master m,
   output logic       busy_o,
   output logic       timeout_o
);
   localparam logic [7:0] CMD_W  = 8'h57;
   localparam logic [7:0] CMD_R  = 8'h52;
   localparam logic [7:0] ST_OK  = 8'h4B;
   localparam logic [7:0] ST_ERR = 8'h45;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_SEND
   } state_t;

   // Assembled command frame.
   typedef struct packed {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;
   } frame_t;

   state_t        state_q, state_d;
   frame_t        frm_q;
   logic [1:0]    byte_cnt_q;
   logic [TW-1:0] tmo_cnt_q;
   logic          aw_done_q, w_done_q;
   logic [31:0]   rdata_q;
   logic [2:0]    send_idx_q, send_last_q;
   logic          tx_start_q;
   logic [7:0]    tx_byte_q;
   logic          timeout_q;

   logic in_frame, tmo_hit, aw_vld, w_vld, aw_hs, w_hs;

   function automatic logic [7:0] status_byte(input logic [1:0] resp);
      return (resp == 2'b00) ? ST_OK : ST_ERR;
   endfunction

   // Constant attributes and registered outputs.
   assign m.m_awprot_o = 3'b000;
   assign m.m_arprot_o = 3'b000;
   assign m.m_wstrb_o  = 4'hF;
   assign m.m_awaddr_o = frm_q.addr[ADDR_WIDTH-1:0];
   assign m.m_araddr_o = frm_q.addr[ADDR_WIDTH-1:0];
   assign m.m_wdata_o  = frm_q.data;
   assign tx_start_o   = tx_start_q;
   assign tx_byte_o    = tx_byte_q;
   assign timeout_o    = timeout_q;

   // State register; async reset drops every valid at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic and handshake outputs (all decoded from registers).
   always_comb begin
      state_d       = state_q;
      busy_o        = (state_q != S_IDLE);
      in_frame      = (state_q == S_ADDR) || (state_q == S_DATA);
      tmo_hit       = in_frame && !rx_valid_i && (tmo_cnt_q == TMO_LAST);
      aw_vld        = (state_q == S_WR_REQ) && !aw_done_q;
      w_vld         = (state_q == S_WR_REQ) && !w_done_q;
      aw_hs         = aw_vld && m.m_awready_i;
      w_hs          = w_vld && m.m_wready_i;
      m.m_awvalid_o = aw_vld;
      m.m_wvalid_o  = w_vld;
      m.m_bready_o  = (state_q == S_WR_RESP);
      m.m_arvalid_o = (state_q == S_RD_REQ);
      m.m_rready_o  = (state_q == S_RD_DATA);
      case (state_q)
         S_IDLE:
            if (rx_valid_i && (rx_byte_i == CMD_W || rx_byte_i == CMD_R))
               state_d = S_ADDR;
         S_ADDR:
            if (tmo_hit) state_d = S_IDLE;
            else if (rx_valid_i && byte_cnt_q == 2'd3)
               state_d = frm_q.is_wr ? S_DATA : S_RD_REQ;
         S_DATA:
            if (tmo_hit) state_d = S_IDLE;
            else if (rx_valid_i && byte_cnt_q == 2'd3) state_d = S_WR_REQ;
         S_WR_REQ:
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WR_RESP;
         S_WR_RESP:
            if (m.m_bvalid_i) state_d = S_SEND;
         S_RD_REQ:
            if (m.m_arready_i) state_d = S_RD_DATA;
         S_RD_DATA:
            if (m.m_rvalid_i) state_d = S_SEND;
         S_SEND:
            if (tx_done_i && send_idx_q == send_last_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Frame shift-in, timeout counter, AXI handshake tracking and tx sequencing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frm_q       <= '0;
         byte_cnt_q  <= '0;
         tmo_cnt_q   <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rdata_q     <= '0;
         send_idx_q  <= '0;
         send_last_q <= '0;
         tx_start_q  <= 1'b0;
         tx_byte_q   <= '0;
         timeout_q   <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         timeout_q  <= tmo_hit;
         // Idle-gap counter only runs while a frame is partially received.
         tmo_cnt_q  <= (in_frame && !rx_valid_i && !tmo_hit) ? tmo_cnt_q + TW'(1) : '0;
         if (state_d != state_q)           byte_cnt_q <= '0;
         else if (in_frame && rx_valid_i)  byte_cnt_q <= byte_cnt_q + 2'd1;
         case (state_q)
            S_IDLE:
               if (rx_valid_i) frm_q.is_wr <= (rx_byte_i == CMD_W);
            S_ADDR:
               if (rx_valid_i) frm_q.addr <= {frm_q.addr[23:0], rx_byte_i};
            S_DATA:
               if (rx_valid_i) frm_q.data <= {frm_q.data[23:0], rx_byte_i};
            S_WR_REQ: begin
               // AW and W retire independently; flags clear on leaving.
               aw_done_q <= (aw_done_q | aw_hs) & (state_d == S_WR_REQ);
               w_done_q  <= (w_done_q | w_hs) & (state_d == S_WR_REQ);
            end
            S_WR_RESP:
               if (m.m_bvalid_i) begin
                  tx_byte_q   <= status_byte(m.m_bresp_i);
                  tx_start_q  <= 1'b1;
                  send_idx_q  <= '0;
                  send_last_q <= 3'd0;
               end
            S_RD_DATA:
               if (m.m_rvalid_i) begin
                  rdata_q     <= m.m_rdata_i;
                  tx_byte_q   <= status_byte(m.m_rresp_i);
                  tx_start_q  <= 1'b1;
                  send_idx_q  <= '0;
                  send_last_q <= (m.m_rresp_i == 2'b00) ? 3'd4 : 3'd0;
               end
            S_SEND:
               // Next byte goes out the cycle after the previous one finishes.
               if (tx_done_i && send_idx_q != send_last_q) begin
                  send_idx_q <= send_idx_q + 3'd1;
                  tx_byte_q  <= rdata_q[31:24];
                  rdata_q    <= {rdata_q[23:0], 8'h00};
                  tx_start_q <= 1'b1;
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_axil_bridge.sv
// Directed bench for uart_axil_bridge: table of frames against an AXI-lite
// slave / uart tx model, plus hand sequences for garbage, timeout, reset.
module tb_uart_axil_bridge;
   logic       clk = 1'b0;
   logic       rst;
   logic       rx_valid_i;
   logic [7:0] rx_byte_i;
   logic       tx_start_o;
   logic [7:0] tx_byte_o;
   logic       tx_done_i;
   logic       busy_o, timeout_o;

   uart_axil_bridge_if #(.ADDR_WIDTH(32)) axi ();

   uart_axil_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst(rst),
      .rx_valid_i(rx_valid_i), .rx_byte_i(rx_byte_i),
      .tx_start_o(tx_start_o), .tx_byte_o(tx_byte_o), .tx_done_i(tx_done_i),
      .m(axi), .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // slave / uart model state
   int          aw_dly, w_dly, ar_dly, r_dly;
   logic [1:0]  cfg_resp;
   logic [31:0] cfg_rdata;
   int          aw_hi, w_hi, ar_hi, b_hi, r_hi;
   logic [31:0] aw_addr, ar_addr, w_data;
   logic [3:0]  w_strb;
   logic [2:0]  aw_prot, ar_prot;
   logic [7:0]  tx_log [8];
   int          ntx, tx_wait, tx_overlap, hold_err, n_tmo, n_axi;
   logic        tx_pend;

   typedef struct {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] data;     // write data, or read data returned by slave
      logic [1:0]  resp;
      int          aw_dly;
      int          w_dly;
      int          ar_dly;
      int          gap;      // idle cycles before each frame byte
      int          exp_ntx;
      logic [39:0] exp_tx;   // first byte in [39:32]
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic clear_model();
      aw_hi = 0; w_hi = 0; ar_hi = 0; b_hi = 0; r_hi = 0;
      aw_addr = 'x; ar_addr = 'x; w_data = 'x; w_strb = 'x; aw_prot = 'x; ar_prot = 'x;
      ntx = 0; tx_pend = 1'b0; tx_wait = 0; tx_overlap = 0; hold_err = 0;
      n_tmo = 0; n_axi = 0; r_dly = 0;
   endtask

   // One clock: advance to the negedge, then update the slave and uart models.
   task automatic tick();
      @(negedge clk);
      if (axi.m_awvalid_o) begin
         aw_hi++;
         axi.m_awready_i = (aw_hi == aw_dly + 1);
         if (axi.m_awready_i) begin aw_addr = axi.m_awaddr_o; aw_prot = axi.m_awprot_o; end
      end else axi.m_awready_i = 1'b0;
      if (axi.m_wvalid_o) begin
         w_hi++;
         axi.m_wready_i = (w_hi == w_dly + 1);
         if (axi.m_wready_i) begin w_data = axi.m_wdata_o; w_strb = axi.m_wstrb_o; end
      end else axi.m_wready_i = 1'b0;
      if (axi.m_arvalid_o) begin
         ar_hi++;
         axi.m_arready_i = (ar_hi == ar_dly + 1);
         if (axi.m_arready_i) begin ar_addr = axi.m_araddr_o; ar_prot = axi.m_arprot_o; end
      end else axi.m_arready_i = 1'b0;
      if (axi.m_bready_o) begin
         b_hi++;
         axi.m_bvalid_i = (b_hi == 1);
         axi.m_bresp_i  = cfg_resp;
      end else axi.m_bvalid_i = 1'b0;
      if (axi.m_rready_o) begin
         r_hi++;
         axi.m_rvalid_i = (r_hi == r_dly + 1);
         axi.m_rdata_i  = cfg_rdata;
         axi.m_rresp_i  = cfg_resp;
      end else axi.m_rvalid_i = 1'b0;
      tx_done_i = 1'b0;
      if (tx_start_o) begin
         if (tx_pend) tx_overlap++;
         if (ntx < 8) tx_log[ntx] = tx_byte_o;
         ntx++;
         tx_pend = 1'b1;
         tx_wait = 3;
      end else if (tx_pend) begin
         if (tx_wait == 0) begin
            tx_done_i = 1'b1;
            tx_pend   = 1'b0;
            if (ntx > 0 && ntx <= 8 && tx_byte_o !== tx_log[ntx-1]) hold_err++;
         end else tx_wait--;
      end
      if (timeout_o) n_tmo++;
      if (axi.m_awvalid_o || axi.m_wvalid_o || axi.m_arvalid_o) n_axi++;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) tick();
      rx_valid_i = 1'b1;
      rx_byte_i  = b;
      tick();
      rx_valid_i = 1'b0;
   endtask

   task automatic send_frame(input logic is_wr, input logic [31:0] addr,
                             input logic [31:0] data, input int gap);
      send_byte(is_wr ? 8'h57 : 8'h52, gap);
      for (int k = 3; k >= 0; k--) send_byte(addr[8*k +: 8], gap);
      if (is_wr) for (int k = 3; k >= 0; k--) send_byte(data[8*k +: 8], gap);
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 800; k++) begin
         if (!busy_o) break;
         tick();
      end
      chk({name, "_idle"}, busy_o, 1'b0);
      repeat (6) tick();
   endtask

   initial begin
      rst = 1'b1; rx_valid_i = 1'b0; rx_byte_i = '0; tx_done_i = 1'b0;
      axi.m_awready_i = 0; axi.m_wready_i = 0; axi.m_bvalid_i = 0; axi.m_bresp_i = 0;
      axi.m_arready_i = 0; axi.m_rvalid_i = 0; axi.m_rdata_i = 0; axi.m_rresp_i = 0;
      aw_dly = 0; w_dly = 0; ar_dly = 0; cfg_resp = 0; cfg_rdata = 0;
      clear_model();

      vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 2'b00, 3, 0, 0, 0,  1, 40'h4B_0000_0000};
      vecs[1] = '{1'b0, 32'h0000_0008, 32'h1234_5678, 2'b00, 0, 0, 0, 1,  5, 40'h4B_1234_5678};
      vecs[2] = '{1'b0, 32'h0000_0100, 32'hCAFE_0000, 2'b10, 0, 0, 1, 0,  1, 40'h45_0000_0000};
      vecs[3] = '{1'b1, 32'h0000_0010, 32'h0102_0304, 2'b11, 0, 2, 0, 0,  1, 40'h45_0000_0000};
      vecs[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 1, 1, 0, 0,  1, 40'h45_0000_0000};
      vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'hA5A5_0001, 2'b00, 0, 0, 2, 99, 5, 40'h4B_A5A5_0001};

      // reset state
      repeat (3) tick();
      chk("rst_ctrl", {tx_start_o, tx_byte_o, busy_o, timeout_o, axi.m_awvalid_o, axi.m_wvalid_o,
                       axi.m_bready_o, axi.m_arvalid_o, axi.m_rready_o}, '0);
      chk("rst_addr", {axi.m_awaddr_o, axi.m_araddr_o}, '0);
      chk("rst_wdata", axi.m_wdata_o, '0);
      rst = 1'b0;
      repeat (2) tick();

      // table-driven frames
      for (int i = 0; i < 6; i++) begin
         clear_model();
         aw_dly = vecs[i].aw_dly; w_dly = vecs[i].w_dly; ar_dly = vecs[i].ar_dly;
         cfg_resp = vecs[i].resp; cfg_rdata = vecs[i].data;
         send_frame(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].gap);
         chk($sformatf("v%0d_latency", i),
             vecs[i].is_wr ? (axi.m_awvalid_o & axi.m_wvalid_o) : axi.m_arvalid_o, 1'b1);
         wait_idle($sformatf("v%0d", i));
         chk($sformatf("v%0d_ntx", i), ntx, vecs[i].exp_ntx);
         for (int k = 0; k < vecs[i].exp_ntx; k++)
            chk($sformatf("v%0d_tx%0d", i, k), tx_log[k], vecs[i].exp_tx[39-8*k -: 8]);
         chk($sformatf("v%0d_txproto", i), tx_overlap + hold_err, 0);
         chk($sformatf("v%0d_notmo", i), n_tmo, 0);
         if (vecs[i].is_wr) begin
            chk($sformatf("v%0d_awaddr", i), aw_addr, vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), w_data, vecs[i].data);
            chk($sformatf("v%0d_wstrb", i), w_strb, 4'hF);
            chk($sformatf("v%0d_awprot", i), aw_prot, 3'b000);
            chk($sformatf("v%0d_aw_cycles", i), aw_hi, vecs[i].aw_dly + 1);
            chk($sformatf("v%0d_w_cycles", i), w_hi, vecs[i].w_dly + 1);
         end else begin
            chk($sformatf("v%0d_araddr", i), ar_addr, vecs[i].addr);
            chk($sformatf("v%0d_arprot", i), ar_prot, 3'b000);
            chk($sformatf("v%0d_ar_cycles", i), ar_hi, vecs[i].ar_dly + 1);
         end
      end

      // garbage bytes are discarded in IDLE
      clear_model(); aw_dly = 0; w_dly = 0; ar_dly = 0; cfg_resp = 2'b00; cfg_rdata = 32'h0BAD_F00D;
      send_byte(8'h00, 1); chk("garb_busy0", busy_o, 1'b0);
      send_byte(8'hFF, 1); chk("garb_busy1", busy_o, 1'b0);
      send_byte(8'h52, 1); chk("garb_busy2", busy_o, 1'b1);
      for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
      chk("garb_arvalid", axi.m_arvalid_o, 1'b1);
      wait_idle("garb");
      chk("garb_araddr", ar_addr, 32'h0);
      chk("garb_ntx", ntx, 5);
      chk("garb_tx4", tx_log[4], 8'h0D);

      // timeout on a stalled partial frame
      clear_model();
      send_byte(8'h57, 1); send_byte(8'h11, 0); send_byte(8'h22, 0);
      begin
         int first = -1;
         for (int k = 1; k <= 200; k++) begin
            tick();
            if (timeout_o) begin first = k; break; end
         end
         chk("tmo_cycle", first, 100);
         chk("tmo_busy", busy_o, 1'b0);
         tick();
         chk("tmo_pulse", timeout_o, 1'b0);
         chk("tmo_count", n_tmo, 1);
         chk("tmo_no_axi", n_axi, 0);
         chk("tmo_no_tx", ntx, 0);
      end
      clear_model();
      send_frame(1'b1, 32'h30, 32'h55, 0);
      wait_idle("tmo_after");
      chk("tmo_after_awaddr", aw_addr, 32'h30);
      chk("tmo_after_tx", {ntx[7:0], tx_log[0]}, {8'd1, 8'h4B});

      // bytes arriving during RD_DATA are dropped
      clear_model(); r_dly = 15; cfg_resp = 2'b00; cfg_rdata = 32'hCAFE_F00D;
      send_frame(1'b0, 32'h20, 32'h0, 0);
      send_byte(8'h57, 0); send_byte(8'h52, 0);
      for (int k = 0; k < 4; k++) send_byte(8'h00, 0);
      wait_idle("rdd");
      chk("rdd_ntx", ntx, 5);
      chk("rdd_tx", {tx_log[0], tx_log[1], tx_log[2], tx_log[3], tx_log[4]}, 40'h4B_CAFE_F00D);
      chk("rdd_no_axi_after", axi.m_awvalid_o | axi.m_arvalid_o | busy_o, 1'b0);

      // async reset while AR is pending
      clear_model(); ar_dly = 1000;
      send_frame(1'b0, 32'h44, 32'h0, 0);
      tick();
      chk("rst_mid_arvalid", axi.m_arvalid_o, 1'b1);
      #2 rst = 1'b1;
      #1 chk("rst_mid_async", {tx_start_o, tx_byte_o, busy_o, timeout_o, axi.m_awvalid_o,
                               axi.m_wvalid_o, axi.m_bready_o, axi.m_arvalid_o, axi.m_rready_o}, '0);
      chk("rst_mid_addr", axi.m_araddr_o, '0);
      repeat (2) tick();
      rst = 1'b0;
      clear_model(); ar_dly = 0; cfg_rdata = 32'h0102_0304;
      tick();
      send_frame(1'b0, 32'h44, 32'h0, 0);
      wait_idle("post_rst");
      chk("post_rst_araddr", ar_addr, 32'h44);
      chk("post_rst_tx", {tx_log[0], tx_log[1], tx_log[4]}, 24'h4B_01_04);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
